// File: rtl/reset_vector_fetch_if.sv
// Interface between reset_vector_fetch, the ROM-emulator front end readout port
// and the host-side valid/ready handshake.
// master: the fetch block (drives index, vector, valid).
// slave:  front end / host (drives chunk data and ready).
interface reset_vector_fetch_if #(
    parameter int unsigned ADDR_N  = 19,
    parameter int unsigned CHUNK_N = 2,
    parameter int unsigned IDX_N   = 5
);
    logic [IDX_N-1:0]   o_idx;
    logic [CHUNK_N-1:0] i_chunk;
    logic [ADDR_N-1:0]  o_reset_addr;
    logic               o_valid;
    logic               i_ready;

    modport master (
        output o_idx,
        input  i_chunk,
        output o_reset_addr,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_idx,
        output i_chunk,
        input  o_reset_addr,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/reset_vector_fetch.sv
// reset_vector_fetch: waits for the front end's set bit, walks its 2-bit readout
// port one index per cycle, reassembles the reset vector and offers it to the
// host with a valid/ready handshake. A rearm in DONE triggers a fresh readout.
// Optional feature macro: RESET_VECTOR_VERIFY_EN adds a second readout pass
// (VERIFY) that compares every chunk against the captured value and sets a
// sticky o_err on any mismatch.
module reset_vector_fetch #(
    parameter int unsigned ADDR_N  = 19,
    parameter int unsigned CHUNK_N = 2,
    parameter int unsigned IDX_N   = 5
) (
    input  logic                 i_clk,
    input  logic                 _rst,
    input  logic                 s,
    reset_vector_fetch_if.master bus,
    input  logic                 i_rearm,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int unsigned      N_CHUNKS = (ADDR_N + CHUNK_N - 1) / CHUNK_N;
    // All-ones index is out of range, so the front end floats its output.
    localparam logic [IDX_N-1:0] IDX_IDLE = '1;
    localparam logic [IDX_N-1:0] IDX_LAST = IDX_N'(N_CHUNKS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StVerify,
        StPresent,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_N-1:0]    idx_q, idx_d;
    logic [ADDR_N-1:0]   addr_q, addr_d;
    logic                s_meta_q, s_sync_q;
    logic [ADDR_N-1:0]   addr_wr;

`ifdef RESET_VECTOR_VERIFY_EN
    logic                err_q, err_d;
    logic                chunk_mis;
`endif

    // Two-flop synchronizer for the asynchronous set bit.
    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            s_meta_q <= 1'b0;
            s_sync_q <= 1'b0;
        end else begin
            s_meta_q <= s;
            s_sync_q <= s_meta_q;
        end
    end

    // Merge the incoming chunk into the vector at the current index; bits of the
    // last chunk above ADDR_N-1 have no home and are dropped.
    always_comb begin
        addr_wr = addr_q;
`ifdef RESET_VECTOR_VERIFY_EN
        chunk_mis = 1'b0;
`endif
        for (int b = 0; b < ADDR_N; b++) begin
            if (IDX_N'(b / CHUNK_N) == idx_q) begin
                addr_wr[b] = bus.i_chunk[b % CHUNK_N];
`ifdef RESET_VECTOR_VERIFY_EN
                chunk_mis = chunk_mis | (addr_q[b] != bus.i_chunk[b % CHUNK_N]);
`endif
            end
        end
    end

    // State, index, vector (and error) registers.
    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= StIdle;
            idx_q   <= IDX_IDLE;
            addr_q  <= '0;
`ifdef RESET_VECTOR_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
`ifdef RESET_VECTOR_VERIFY_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic: one readout index per cycle, then present and hold.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
`ifdef RESET_VECTOR_VERIFY_EN
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (s_sync_q) begin
                    state_d = StFetch;
                    idx_d   = '0;
                end
            end
            StFetch: begin
                // Set bit is not rechecked here: a started capture always completes.
                addr_d = addr_wr;
                if (idx_q == IDX_LAST) begin
`ifdef RESET_VECTOR_VERIFY_EN
                    state_d = StVerify;
                    idx_d   = '0;
`else
                    state_d = StPresent;
                    idx_d   = IDX_IDLE;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`ifdef RESET_VECTOR_VERIFY_EN
            StVerify: begin
                // First-pass value is kept; the second pass only flags differences.
                if (chunk_mis) begin
                    err_d = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = StPresent;
                    idx_d   = IDX_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`endif
            StPresent: begin
                if (bus.i_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Set bit is sticky in the front end, so no resync on rearm.
                if (i_rearm) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = IDX_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; busy also covers the sync window.
    always_comb begin
        bus.o_idx        = idx_q;
        bus.o_reset_addr = addr_q;
        bus.o_valid      = (state_q == StPresent);
        o_busy           = (state_q == StFetch) || (state_q == StVerify) ||
                           ((state_q == StIdle) && s_meta_q);
`ifdef RESET_VECTOR_VERIFY_EN
        o_err            = err_q;
`else
        o_err            = 1'b0;
`endif
    end

endmodule

// File: tb/tb_reset_vector_fetch.sv
// Directed bench for reset_vector_fetch with a behavioural front-end model that
// updates its readout data on the falling edge.
module tb_reset_vector_fetch;

`ifdef RESET_VECTOR_VERIFY_EN
    localparam int LAT  = 23;
    localparam int NIDX = 20;
`else
    localparam int LAT  = 13;
    localparam int NIDX = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic s;
    logic rearm;
    logic busy;
    logic err;

    int checks = 0;
    int passed = 0;

    logic [18:0] model_val;
    bit          corrupt;
    int          pass_cnt;
    logic [19:0] m_ext;
    logic [1:0]  m_c;
    int          m_k;

    reset_vector_fetch_if #(.ADDR_N(19), .CHUNK_N(2), .IDX_N(5)) bus ();

    reset_vector_fetch #(.ADDR_N(19), .CHUNK_N(2), .IDX_N(5)) dut (
        .i_clk   (clk),
        ._rst    (rst_n),
        .s       (s),
        .bus     (bus),
        .i_rearm (rearm),
        .o_busy  (busy),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    // Front-end readout model: output changes on the negedge of the index cycle.
    always @(negedge clk) begin
        m_k = int'(bus.o_idx);
        if (m_k == 0) pass_cnt++;
        m_ext = {1'b0, model_val};
        if (m_k < 10) begin
            m_c = m_ext[m_k*2 +: 2];
            if (corrupt && pass_cnt == 2 && m_k == 3) m_c = m_c ^ 2'b01;
            bus.i_chunk <= m_c;
        end else begin
            bus.i_chunk <= 2'b00;
        end
    end

    // Observes a readout until o_valid, recording latency and index sequence.
    task automatic run_fetch(input int start_k, output int cyc, output bit seq_ok,
                             output int n_idx);
        int exp_k;
        exp_k  = start_k;
        seq_ok = 1'b1;
        n_idx  = 0;
        cyc    = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.o_idx != 5'h1F) begin
                if (int'(bus.o_idx) != exp_k) seq_ok = 1'b0;
                n_idx++;
                exp_k = (exp_k == 9) ? 0 : exp_k + 1;
            end
            if (bus.o_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; s = 1'b0; rearm = 1'b0; bus.i_ready = 1'b0;
        corrupt = 1'b0; pass_cnt = 0; model_val = 19'h0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_idx !== 5'h1F) $display("FAIL reset_idx: got %h want 1f", bus.o_idx); else passed++;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h0) $display("FAIL reset_addr: got %h want 0", bus.o_reset_addr); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.o_idx !== 5'h1F) $display("FAIL idle_idx: got %h want 1f", bus.o_idx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_fetch();
        int cyc; bit ok; int n;
        model_val = 19'h4ABCD;
        @(posedge clk); #1;
        s = 1'b1;
        run_fetch(0, cyc, ok, n);
        checks++; if (!(cyc > 0 && cyc <= LAT)) $display("FAIL fetch_latency: got %0d want 1..%0d", cyc, LAT); else passed++;
        checks++; if (ok !== 1'b1) $display("FAIL fetch_idx_seq: got %b want 1", ok); else passed++;
        checks++; if (n != NIDX) $display("FAIL fetch_idx_count: got %0d want %0d", n, NIDX); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h4ABCD) $display("FAIL fetch_addr: got %h want 4abcd", bus.o_reset_addr); else passed++;
        checks++; if (bus.o_idx !== 5'h1F) $display("FAIL present_idx: got %h want 1f", bus.o_idx); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL fetch_err: got %b want 0", err); else passed++;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.o_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.o_valid); else passed++;
            checks++; if (bus.o_reset_addr !== 19'h4ABCD) $display("FAIL hold_addr[%0d]: got %h want 4abcd", i, bus.o_reset_addr); else passed++;
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL accept_valid: got %b want 0", bus.o_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL done_busy: got %b want 0", busy); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.o_reset_addr !== 19'h4ABCD) $display("FAIL done_addr: got %h want 4abcd", bus.o_reset_addr); else passed++;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL done_valid: got %b want 0", bus.o_valid); else passed++;
        checks++; if (bus.o_idx !== 5'h1F) $display("FAIL done_idx: got %h want 1f", bus.o_idx); else passed++;
    endtask

    task automatic test_rearm();
        int cyc; bit ok; int n;
        model_val = 19'h12345;
        rearm = 1'b1;
        @(posedge clk); #1;
        rearm = 1'b0;
        checks++; if (bus.o_idx !== 5'h00) $display("FAIL rearm_idx0: got %h want 00", bus.o_idx); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h0) $display("FAIL rearm_clear: got %h want 0", bus.o_reset_addr); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL rearm_busy: got %b want 1", busy); else passed++;
        // Rearm, dropped set bit and early ready mid-fetch must all be ignored.
        rearm = 1'b1; s = 1'b0; bus.i_ready = 1'b1;
        @(posedge clk); #1;
        rearm = 1'b0; bus.i_ready = 1'b0;
        checks++; if (bus.o_idx !== 5'h01) $display("FAIL rearm_in_fetch_idx: got %h want 01", bus.o_idx); else passed++;
        run_fetch(2, cyc, ok, n);
        checks++; if (cyc < 0) $display("FAIL refetch_timeout: got %0d want >0", cyc); else passed++;
        checks++; if (ok !== 1'b1) $display("FAIL refetch_idx_seq: got %b want 1", ok); else passed++;
        checks++; if (n != NIDX - 2) $display("FAIL refetch_idx_count: got %0d want %0d", n, NIDX - 2); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h12345) $display("FAIL refetch_addr: got %h want 12345", bus.o_reset_addr); else passed++;
        rearm = 1'b1;
        @(posedge clk); #1;
        rearm = 1'b0;
        checks++; if (bus.o_valid !== 1'b1) $display("FAIL rearm_present_valid: got %b want 1", bus.o_valid); else passed++;
        checks++; if (bus.o_idx !== 5'h1F) $display("FAIL rearm_present_idx: got %h want 1f", bus.o_idx); else passed++;
        bus.i_ready = 1'b1; rearm = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0; rearm = 1'b0;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL hs_rearm_valid: got %b want 0", bus.o_valid); else passed++;
        checks++; if (bus.o_idx !== 5'h1F) $display("FAIL hs_rearm_idx: got %h want 1f", bus.o_idx); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.o_idx !== 5'h1F) $display("FAIL hs_rearm_idx_late: got %h want 1f", bus.o_idx); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h12345) $display("FAIL hs_rearm_addr: got %h want 12345", bus.o_reset_addr); else passed++;
        s = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        int cyc; bit ok; int n; bit found;
        model_val = 19'h4ABCD;
        found = 1'b0;
        rearm = 1'b1;
        @(posedge clk); #1;
        rearm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_idx == 5'h04) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++; if (found !== 1'b1) $display("FAIL mid_idx4_reached: got %b want 1", found); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_idx !== 5'h1F) $display("FAIL mid_rst_idx: got %h want 1f", bus.o_idx); else passed++;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", bus.o_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h0) $display("FAIL mid_rst_addr: got %h want 0", bus.o_reset_addr); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_fetch(0, cyc, ok, n);
        checks++; if (!(cyc > 0 && cyc <= LAT)) $display("FAIL post_rst_latency: got %0d want 1..%0d", cyc, LAT); else passed++;
        checks++; if (ok !== 1'b1) $display("FAIL post_rst_idx_seq: got %b want 1", ok); else passed++;
        checks++; if (n != NIDX) $display("FAIL post_rst_idx_count: got %0d want %0d", n, NIDX); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h4ABCD) $display("FAIL post_rst_addr: got %h want 4abcd", bus.o_reset_addr); else passed++;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
    endtask

`ifdef RESET_VECTOR_VERIFY_EN
    task automatic test_verify();
        int cyc; bit ok; int n;
        model_val = 19'h4ABCD;
        corrupt   = 1'b1;
        pass_cnt  = 0;
        checks++; if (err !== 1'b0) $display("FAIL verify_err_before: got %b want 0", err); else passed++;
        rearm = 1'b1;
        @(posedge clk); #1;
        rearm = 1'b0;
        run_fetch(0, cyc, ok, n);
        checks++; if (n != 20) $display("FAIL verify_idx_count: got %0d want 20", n); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL verify_err_set: got %b want 1", err); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h4ABCD) $display("FAIL verify_addr: got %h want 4abcd", bus.o_reset_addr); else passed++;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL verify_err_sticky: got %b want 1", err); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0) $display("FAIL verify_err_rst: got %b want 0", err); else passed++;
        corrupt = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_fetch(0, cyc, ok, n);
        checks++; if (cyc != 23) $display("FAIL verify_latency: got %0d want 23", cyc); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL verify_clean_err: got %b want 0", err); else passed++;
        checks++; if (bus.o_reset_addr !== 19'h4ABCD) $display("FAIL verify_clean_addr: got %h want 4abcd", bus.o_reset_addr); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_hold();
        test_rearm();
        test_reset_mid_fetch();
`ifdef RESET_VECTOR_VERIFY_EN
        test_verify();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
